// File: rtl/trace_capture_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// trace_capture_ctrl: triggered trace capture into a double-buffered sample
// memory, with a registered per-column lookup port for the display path.
// Revision 1.0 - initial release
// ============================================================================
module trace_capture_ctrl #(
   parameter int NPTS    = 640,
   parameter int YMAX    = 479,
   parameter int TIMEOUT = 2048
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_valid,
   input  logic [9:0] sample_data,
   input  logic [9:0] trig_level,
   input  logic       mode,
   input  logic       arm,
   input  logic       frame_start,
   input  logic [9:0] rd_x,
   output logic [9:0] rd_y,
   output logic       trace_valid,
   output logic [1:0] state
);
   localparam int              AW       = (NPTS > 1) ? $clog2(NPTS) : 1;
   localparam int              CW       = $clog2(TIMEOUT + 1);
   localparam logic [9:0]      YMAX_V   = 10'(YMAX);
   localparam logic [9:0]      NO_ROW   = 10'h3FF;
   localparam logic [AW-1:0]   LAST_IDX = AW'(NPTS - 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t          cur_state;
   state_t          next_state;
   logic            bank_sel;
   logic [AW-1:0]   wr_idx;
   logic [CW-1:0]   tmo_cnt;
   logic            prev_valid;
   logic [9:0]      prev_sample;

   // bank_sel names the front (display) bank; the other one is written.
   logic [9:0]      bank0 [NPTS];
   logic [9:0]      bank1 [NPTS];

   logic            edge_trig;
   logic            tmo_trig;
   logic            trig;
   logic            wr_en;
   logic            last_wr;
   logic            swap;
   logic [AW-1:0]   wr_addr;
   logic [9:0]      wr_data;
   logic [AW-1:0]   rd_addr;

   always_comb begin
      edge_trig  = sample_valid && prev_valid &&
                   (prev_sample < trig_level) && (sample_data >= trig_level);
      tmo_trig   = sample_valid && mode && (tmo_cnt == CNT_LAST);
      trig       = (cur_state == ARMED) && (edge_trig || tmo_trig);
      wr_en      = trig || ((cur_state == CAPTURE) && sample_valid);
      wr_addr    = (cur_state == CAPTURE) ? wr_idx : '0;
      wr_data    = (sample_data > YMAX_V) ? YMAX_V : sample_data;
      last_wr    = (cur_state == CAPTURE) && sample_valid && (wr_idx == LAST_IDX);
      swap       = (cur_state == DONE) && frame_start;
      next_state = cur_state;
      case (cur_state)
         IDLE:    if (arm)         next_state = ARMED;
         ARMED:   if (trig)        next_state = CAPTURE;
         CAPTURE: if (last_wr)     next_state = DONE;
         DONE:    if (frame_start) next_state = mode ? ARMED : IDLE;
         default:                  next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state   <= IDLE;
         bank_sel    <= 1'b0;
         trace_valid <= 1'b0;
         wr_idx      <= '0;
         tmo_cnt     <= '0;
         prev_valid  <= 1'b0;
         prev_sample <= '0;
      end else begin
         cur_state <= next_state;
         if ((next_state == ARMED) && (cur_state != ARMED)) begin
            prev_valid <= 1'b0;
            tmo_cnt    <= '0;
            wr_idx     <= '0;
         end else if (cur_state == ARMED) begin
            if (sample_valid) begin
               prev_valid  <= 1'b1;
               prev_sample <= sample_data;
               if (mode) tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (trig) wr_idx <= AW'(1);
         end else if ((cur_state == CAPTURE) && sample_valid && !last_wr) begin
            wr_idx <= wr_idx + 1'b1;
         end
         if (swap) begin
            bank_sel    <= ~bank_sel;
            trace_valid <= 1'b1;
         end
      end
   end

   // Memory contents survive reset; trace_valid masks whatever is stale.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (bank_sel) bank0[wr_addr] <= wr_data;
         else          bank1[wr_addr] <= wr_data;
      end
   end

   assign rd_addr = rd_x[AW-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_y <= NO_ROW;
      end else if (!trace_valid || (32'(rd_x) >= NPTS)) begin
         rd_y <= NO_ROW;
      end else begin
         rd_y <= bank_sel ? bank1[rd_addr] : bank0[rd_addr];
      end
   end

   assign state = cur_state;

endmodule
`default_nettype wire

// File: doc/trace_capture_ctrl.md
TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 SHALL have parameter NPTS, default 640, meaning trace length in samples (one per display column).
REQ-002 SHALL have parameter YMAX, default 479, meaning largest storable sample value (last visible row).
REQ-003 SHALL have parameter TIMEOUT, default 2048, meaning valid samples in ARMED before auto mode forces a trigger.
REQ-004 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port sample_valid, input, 1, meaning sample_data is valid this cycle.
REQ-007 SHALL have port sample_data, input, 10, meaning unsigned sample value, in row units.
REQ-008 SHALL have port trig_level, input, 10, meaning rising-edge trigger threshold.
REQ-009 SHALL have port mode, input, 1, meaning 0 = single-shot and 1 = auto re-arm plus timeout trigger.
REQ-010 SHALL have port arm, input, 1, meaning one-cycle pulse that starts a capture from IDLE.
REQ-011 SHALL have port frame_start, input, 1, meaning one-cycle pulse at the start of vertical blanking.
REQ-012 SHALL have port rd_x, input, 10, meaning display column to look up (pix_x).
REQ-013 SHALL have port rd_y, output, 10, meaning stored trace row for rd_x, compared by the display path with pix_y.
REQ-014 SHALL have port trace_valid, output, 1, meaning the front bank holds a completed trace.
REQ-015 SHALL have port state, output, 2, meaning FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.

Function
REQ-016 SHALL hold two NPTS x 10-bit banks, front (read) and back (write), selected by an internal bank_sel bit.
REQ-017 SHALL clamp every stored sample to min(sample_data, YMAX).
REQ-018 SHALL, in IDLE, go to ARMED on arm=1 and ignore arm in every other state.
REQ-019 SHALL, on entry to ARMED, clear the previous-sample-valid flag, the timeout counter and the write index.
REQ-020 SHALL detect a trigger in ARMED when sample_valid=1, prev_valid=1, prev_sample < trig_level and sample_data >= trig_level, comparing unclamped values.
REQ-021 SHALL, in ARMED with mode=1, count valid samples and force a trigger on the valid sample that brings the count to TIMEOUT.
REQ-022 SHALL write the triggering sample to back-bank index 0, move to CAPTURE and set the write index to 1, all in the trigger cycle.
REQ-023 SHALL, in CAPTURE, write each valid sample to the back bank at the write index, then increment the index; cycles with sample_valid=0 write nothing.
REQ-024 SHALL move from CAPTURE to DONE on the cycle that writes index NPTS-1, and SHALL NOT wrap the write index.
REQ-025 SHALL, in DONE, ignore samples and, on frame_start=1, toggle bank_sel, set trace_valid=1, and go to ARMED if mode=1 or to IDLE if mode=0.
REQ-026 SHALL ignore frame_start in IDLE, ARMED and CAPTURE, so the front bank never changes mid-frame.
REQ-027 SHALL wait for the next frame_start pulse when the final write and frame_start coincide, because frame_start is not yet seen in DONE.
REQ-028 SHALL register rd_y one cycle after rd_x from the front bank.
REQ-029 SHALL set rd_y to 10'h3FF, which never matches a visible row, when trace_valid=0 or rd_x >= NPTS.
REQ-030 SHALL sample mode only where REQ-021 and REQ-025 use it, so mode changes mid-capture have no effect until those points.
REQ-031 SHALL keep the read port independent of the write port, and SHALL NOT read from the bank being written.

Reset
REQ-032 SHALL set state=IDLE, bank_sel=0, trace_valid=0, rd_y=10'h3FF, write index=0, timeout counter=0 and prev_valid=0 on reset=1 at a clk edge.
REQ-033 SHALL NOT clear memory contents on reset; trace_valid=0 masks stale data.
REQ-034 SHALL abandon a capture on reset in any state, and the next trace SHALL need a new arm, or mode=1 plus arm.

Verification
REQ-035 Single-shot: mode=0, arm, then ramp 0,1,2,... with trig_level=100 -> trigger on sample 100; rd_x=0 gives 100 and rd_x=639 gives 479 (clamped 739) after frame_start; state=IDLE.
REQ-036 Auto timeout: mode=1, arm, constant sample 50 with trig_level=100 -> CAPTURE entered on the 2048th valid sample; after frame_start, all 640 columns read 50.
REQ-037 Bank swap timing: complete a capture, hold frame_start low for 3 frames of reads -> rd_y stays 10'h3FF (trace_valid=0); next frame_start -> trace_valid=1 and new data appears.
REQ-038 Coincidence: final write cycle coincides with frame_start -> no swap; swap happens on the following frame_start.
REQ-039 Gapped input: sample_valid toggles 1,0,1,0 during CAPTURE -> exactly 640 writes, in order, at indices 0..639.
REQ-040 Mid-capture reset: reset at write index 300 -> state=IDLE, trace_valid=0, rd_y=10'h3FF; arm restarts the capture at index 0.
